// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals between four requesters and the arbiter.
// The master modport is the arbiter side; slave is the requester side.
interface bus_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] enable;
    logic [1:0] owner;
    logic       bus_idle;

    modport master (
        input  req,
        output grant,
        output enable,
        output owner,
        output bus_idle
    );

    modport slave (
        output req,
        input  grant,
        input  enable,
        input  owner,
        input  bus_idle
    );
endinterface

// File: rtl/bus_arbiter.sv
// Four-way round-robin arbiter for a shared tri-state bus, with a bounded tenure
// and a mandatory one-cycle turnaround between owners.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst_n,
    bus_arbiter_if.master bus
);

    localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StTurn
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] owner_q, owner_d;
    logic       idle_q, idle_d;
    logic [1:0] winner;

    // First set request at or after p, wrapping modulo 4; lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb winner = rr_pick(bus.req, ptr_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        owner_d = owner_q;
        idle_d  = idle_q;
        unique case (state_q)
            StIdle, StTurn: begin
                if (|bus.req) begin
                    state_d = StGrant;
                    grant_d = 4'b0001 << winner;
                    owner_d = winner;
                    idle_d  = 1'b0;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                    owner_d = 2'd0;
                    idle_d  = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            StGrant: begin
                if (!bus.req[owner_q] || cnt_q == HoldMax) begin
                    state_d = StTurn;
                    ptr_d   = owner_q + 2'd1;
                    grant_d = 4'b0000;
                    owner_d = 2'd0;
                    idle_d  = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
                owner_d = 2'd0;
                idle_d  = 1'b1;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            grant_q <= 4'b0000;
            owner_q <= 2'd0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            idle_q  <= idle_d;
        end
    end

    // Enable mirrors the registered grant so reset releases the bus immediately.
    assign bus.grant    = grant_q;
    assign bus.enable   = grant_q;
    assign bus.owner    = owner_q;
    assign bus.bus_idle = idle_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized invariant check.
module tb_bus_arbiter;

    localparam int unsigned MaxHold = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bus_arbiter_if bus ();

    bus_arbiter #(
        .MAX_HOLD(MaxHold)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       idle;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] g, input logic [1:0] o,
                           input logic idle);
        chk({name, ".grant"}, 8'(bus.grant), 8'(g));
        chk({name, ".enable"}, 8'(bus.enable), 8'(g));
        chk({name, ".owner"}, 8'(bus.owner), 8'(o));
        chk({name, ".idle"}, 8'(bus.bus_idle), 8'(idle));
    endtask

    task automatic step(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("reset", 4'b0000, 2'd0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [3:0] prev_g;
    logic [3:0] exp_g;
    int         tenure;
    int         rnd_err;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        bus.req = 4'b0000;

        vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b1};
        vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        vecs[2]  = '{4'b0101, 4'b0100, 2'd2, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b1};
        vecs[4]  = '{4'b1010, 4'b1000, 2'd3, 1'b0};
        vecs[5]  = '{4'b1010, 4'b1000, 2'd3, 1'b0};
        vecs[6]  = '{4'b0010, 4'b0000, 2'd0, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b1};
        vecs[8]  = '{4'b0011, 4'b0001, 2'd0, 1'b0};
        vecs[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b1};
        vecs[10] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 2'd0, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 2'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].req);
            chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].idle);
        end

        // Full rotation with every requester holding through expiry.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < int'(MaxHold); c++) begin
                step(4'b1111);
                exp_g = 4'b0001 << r;
                chk($sformatf("rot%0d_c%0d", r, c), 8'(bus.grant), 8'(exp_g));
            end
            step(4'b1111);
            chk($sformatf("rot%0d_turn", r), 8'(bus.grant), 8'h0);
        end
        step(4'b1111);
        chk("rot_wrap", 8'(bus.grant), 8'h1);

        // Single requester held past expiry comes back after one turn cycle.
        do_reset();
        for (int c = 0; c < int'(MaxHold); c++) step(4'b0100);
        step(4'b0100);
        chk("solo_turn", 8'(bus.grant), 8'h0);
        step(4'b0100);
        chk("solo_regrant", 8'(bus.grant), 8'h4);

        // Owner 1 releases after three cycles while requester 3 waits.
        do_reset();
        step(4'b1010);
        chk("drop_g1", 8'(bus.grant), 8'h2);
        step(4'b1010);
        step(4'b1010);
        chk("drop_g3", 8'(bus.grant), 8'h2);
        step(4'b1000);
        chk("drop_turn", 8'(bus.grant), 8'h0);
        step(4'b1000);
        chk_all("drop_next", 4'b1000, 2'd3, 1'b0);

        // Mid-tenure asynchronous reset with ptr moved away from zero.
        do_reset();
        step(4'b0100);
        step(4'b0000);
        step(4'b1000);
        chk("pre_rst", 8'(bus.grant), 8'h8);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 4'b0000, 2'd0, 1'b1);
        #2 rst_n = 1'b1;
        step(4'b1010);
        chk_all("post_rst", 4'b0010, 2'd1, 1'b0);

        // Random stream against structural invariants.
        do_reset();
        prev_g  = 4'b0000;
        tenure  = 0;
        rnd_err = 0;
        for (int n = 0; n < 10000; n++) begin
            step(4'($urandom_range(0, 15)));
            checks++;
            if (!$onehot0(bus.grant) || bus.enable !== bus.grant ||
                bus.bus_idle !== (bus.grant == 4'b0000) ||
                (bus.grant != 4'b0000 && (4'b0001 << bus.owner) != bus.grant) ||
                (bus.grant == 4'b0000 && bus.owner != 2'd0) ||
                (prev_g != 4'b0000 && bus.grant != 4'b0000 && prev_g != bus.grant)) begin
                errors++;
                rnd_err++;
                if (rnd_err <= 10)
                    $display("FAIL rand_inv: grant %b enable %b owner %0d idle %b prev %b",
                             bus.grant, bus.enable, bus.owner, bus.bus_idle, prev_g);
            end
            if (bus.grant != 4'b0000 && bus.grant == prev_g) tenure++;
            else if (bus.grant != 4'b0000) tenure = 1;
            else tenure = 0;
            checks++;
            if (tenure > int'(MaxHold)) begin
                errors++;
                rnd_err++;
                if (rnd_err <= 10)
                    $display("FAIL rand_tenure: got %0d required <= %0d", tenure, MaxHold);
            end
            prev_g = bus.grant;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles per tenure; legal range 1..15.
REQ-002 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Req  input  4  SHALL carry one request per requester; bit i high = requester i wants the shared 4-bit bus.
REQ-005 Grant  output  4  SHALL be one-hot or zero; bit i high = requester i owns the bus this cycle.
REQ-006 Enable  output  4  SHALL drive the enable input of requester i's tri-state buffer onto the shared bus; always equal to Grant.
REQ-007 Owner  output  2  SHALL give the index of the current owner; 0 when no grant.
REQ-008 BusIdle  output  1  SHALL be high when Grant is zero.

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT and TURN; Grant, Enable, Owner and BusIdle SHALL be registered outputs decoded from state.
REQ-010 IDLE: Grant=0. Any Req bit high at a rising edge SHALL move the FSM to GRANT with the winner's Grant bit set from the next cycle (latency 1).
REQ-011 Winner selection SHALL be round-robin: search Req from index Ptr upward, modulo 4; the first set bit wins.
REQ-012 Ptr (2 bits) SHALL be set to (owner+1) mod 4 on each exit from GRANT.
REQ-013 GRANT: a 4-bit tenure counter SHALL load 1 on entry and increment each further cycle in GRANT.
REQ-014 GRANT SHALL exit to TURN at the edge where Req[owner] is low, or where the counter equals MAX_HOLD, whichever comes first.
REQ-015 TURN SHALL last exactly one cycle with Grant=0 and Enable=0, so no two buffers ever drive the bus in adjacent cycles.
REQ-016 In TURN, arbitration SHALL run on the current Req using the updated Ptr. If any bit is set, the next state SHALL be GRANT; otherwise it SHALL be IDLE.
REQ-017 A requester holding Req through its MAX_HOLD expiry SHALL be re-granted only when round-robin reaches it again. With no other requests, this SHALL be after a single TURN cycle.
REQ-018 At most one Grant bit SHALL ever be high. Grant SHALL never change from one nonzero value to another without an intervening all-zero cycle.
REQ-019 Req bits of non-owners SHALL not affect an ongoing tenure.
REQ-020 A Req pulse that rises and falls while the FSM is in GRANT or TURN, and is low at the next arbitration edge, SHALL be ignored.

Reset
REQ-021 Asserting Reset_n low SHALL immediately, without waiting for a clock, set state=IDLE, Grant=0, Enable=0, Owner=0, BusIdle=1, Ptr=0 and counter=0.
REQ-022 Reset asserted mid-tenure SHALL drop Enable at once (bus released to Z). After release, the first arbitration SHALL start from index 0.
REQ-023 Reset_n release SHALL take effect at the first rising edge of Clock after deassertion.

Verification
REQ-024 Reset, then Req=4'b0100 from cycle 0 -> Grant=4'b0100, Enable=4'b0100, Owner=2 at cycle 1; BusIdle=0.
REQ-025 Req=4'b1111 held (MAX_HOLD=8) -> grants 0001 (8 cycles), 0000 (1 cycle), 0010, 0000, 0100, 0000, 1000, 0000, 0001 in rotation.
REQ-026 Owner 1 drops Req after 3 granted cycles while Req[3] is high -> one TURN cycle with Grant=0, then Grant=4'b1000.
REQ-027 Reset_n pulsed low mid-tenure between clock edges -> Enable=0 before the next edge. After release, Req=4'b1010 -> Grant=4'b0010.
REQ-028 Random Req stream over 10k cycles -> checker confirms Grant is one-hot or zero, Enable==Grant, no tenure exceeds MAX_HOLD, and every nonzero-to-nonzero Grant change passes through 0000.
